// File: rtl/xor_pkg.sv
// xor_pkg: shared types and helpers for the XOR engine stream driver
package xor_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_ERR
    } state_t;

    // Rotate left by r; the upper half of the doubled word is the rotated value
    function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x, input logic [4:0] r);
        logic [2*WORD_W-1:0] d;
        d = {x, x} << r;
        return d[2*WORD_W-1:WORD_W];
    endfunction

endpackage

// File: rtl/xor_result_fifo.sv
// xor_result_fifo: small register FIFO holding ciphertext words with their last flags
module xor_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // A pop frees the slot the same cycle, so a push into a full FIFO is legal alongside it
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/xor_stream_driver.sv
// xor_stream_driver: valid/ready front-end that feeds the XOR engine one word at a time and queues its results
module xor_stream_driver
    import xor_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ROT     = 1,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [WORD_W-1:0] key_seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              enc_start,
    output logic [WORD_W-1:0] enc_data,
    output logic [WORD_W-1:0] enc_key,
    input  logic              enc_done,
    input  logic [WORD_W-1:0] enc_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // cnt is 0 in the first WAIT cycle (one cycle after start), so this value marks TIMEOUT-1 cycles since start
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 2);

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [WORD_W-1:0]       key_q, seed_q;
    logic                    last_q;
    logic                    take, done_ok, timeout;
    logic                    fifo_full, fifo_empty, pop;
    logic [$clog2(DEPTH):0]  fifo_count;

    assign take    = in_valid && in_ready;
    assign done_ok = (state == ST_WAIT) && enc_done;
    assign timeout = (state == ST_WAIT) && !enc_done && (cnt == TMO_LAST);
    assign pop     = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: one word in flight, a fixed gap after each result, ERR is terminal
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = take ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = done_ok ? ST_GAP : timeout ? ST_ERR : ST_WAIT;
            ST_GAP:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_ERR;
        endcase
    end

    // Outputs decoded from state; in_ready is held low while reset is asserted
    always_comb begin
        in_ready  = !rst && (state == ST_IDLE) && !fifo_full;
        enc_start = state == ST_ISSUE;
        busy      = (state != ST_IDLE) || (fifo_count != '0);
        out_valid = !fifo_empty;
    end

    // Word latch toward the engine, timeout counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_data <= '0;
            enc_key  <= '0;
            last_q   <= 1'b0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            if (take) begin
                enc_data <= in_data;
                enc_key  <= key_q;
                last_q   <= in_last;
            end
            cnt <= (state == ST_ISSUE) ? '0 : (state == ST_WAIT) ? cnt + 1'b1 : cnt;
            if (timeout) err <= 1'b1;
        end
    end

    // Rolling key: load when idle, rotate after each result, restart from the seed after a packet end
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q  <= '0;
            seed_q <= '0;
        end else if (key_load && !busy) begin
            key_q  <= key_seed;
            seed_q <= key_seed;
        end else if (done_ok) begin
            key_q <= last_q ? seed_q : rotl32(key_q, 5'(ROT));
        end
    end

    xor_result_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (done_ok),
        .pop   (pop),
        .din   ({enc_result, last_q}),
        .dout  ({out_data, out_last}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_xor_stream_driver.sv
// tb_xor_stream_driver: directed scoreboard bench for xor_stream_driver with a behavioural two-cycle engine
module tb_xor_stream_driver;

    localparam int DEPTH = 4;
    localparam int ROT   = 1;
    localparam int TO    = 8;

    logic        clk = 1'b0, rst = 1'b1, key_load = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [31:0] key_seed = '0, in_data = '0;
    logic        in_ready, enc_start, enc_done, out_valid, out_last, busy, err;
    logic [31:0] enc_data, enc_key, enc_result, out_data;

    logic        eng_en = 1'b1, eng_done = 1'b0, s1 = 1'b0, spur_done = 1'b0;
    logic [31:0] r1 = '0, eng_res = '0, spur_res = '0;

    logic [32:0] exp_q[$];
    logic [32:0] e_head;
    int          n_assert = 0, n_fail = 0;
    time         t_hs = 0;

    always #5 clk = ~clk;

    assign enc_done   = eng_done | spur_done;
    assign enc_result = eng_done ? eng_res : spur_res;

    xor_stream_driver #(.DEPTH(DEPTH), .ROT(ROT), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .key_seed   (key_seed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .enc_start  (enc_start),
        .enc_data   (enc_data),
        .enc_key    (enc_key),
        .enc_done   (enc_done),
        .enc_result (enc_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .err        (err)
    );

    // Engine model: done and data^key two cycles after start, unaffected by the driver's reset
    always @(posedge clk) begin
        s1       <= enc_start && eng_en;
        r1       <= enc_data ^ enc_key;
        eng_done <= s1;
        eng_res  <= r1;
    end

    // Output side of the scoreboard: every accepted head must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL out_extra got=%h/%b exp=none", out_data, out_last);
            end
            if (exp_q.size() != 0) begin
                e_head = exp_q.pop_front();
                n_assert++;
                assert ({out_data, out_last} === e_head) else begin
                    n_fail++;
                    $error("FAIL out_word got=%h/%b exp=%h/%b", out_data, out_last, e_head[32:1], e_head[0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
        int s = r % 32;
        return (s == 0) ? x : (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] xd(input int i);
        return 32'(i) * 32'h1111_1111;
    endfunction

    function automatic logic [31:0] xc(input int i);
        return xd(i) ^ rotl(32'h0F0F_0000, i * ROT);
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [31:0] s);
        step();
        key_load = 1'b1;
        key_seed = s;
        step();
        key_load = 1'b0;
    endtask

    // Returns 2 time units into the cycle after the handshake edge (cycle 1)
    task automatic send(input logic [31:0] d, input logic l, input logic use_exp, input logic [32:0] e);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && w < 60) begin
            w++;
            @(negedge clk);
        end
        n_assert++;
        assert (in_ready === 1'b1) else begin
            n_fail++;
            $error("FAIL hs_wait got in_ready=%b exp=1", in_ready);
        end
        if (in_ready && use_exp) exp_q.push_back(e);
        @(posedge clk);
        t_hs = $time;
        #2 in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            w++;
            @(negedge clk);
        end
        chk32("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        time t1;
        int  n_st;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_enc_start", enc_start, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_enc_data", enc_data, 32'h0);
        chk32("rst_enc_key", enc_key, 32'h0);
        chk32("rst_out_data", out_data, 32'h0);
        step();
        rst = 1'b0;

        // Single word, latency profile
        load(32'h0000_00FF);
        send(32'h1234_5678, 1'b1, 1'b1, {32'h1234_5687, 1'b1});
        @(negedge clk);
        chk1("a_start_c1", enc_start, 1'b1);
        chk32("a_enc_data", enc_data, 32'h1234_5678);
        chk32("a_enc_key", enc_key, 32'h0000_00FF);
        @(negedge clk);
        chk1("a_start_c2", enc_start, 1'b0);
        chk1("a_busy", busy, 1'b1);
        @(negedge clk);
        chk1("a_ovalid_c3", out_valid, 1'b0);
        @(negedge clk);
        chk1("a_ovalid_c4", out_valid, 1'b1);
        chk32("a_odata", out_data, 32'h1234_5687);
        chk1("a_olast", out_last, 1'b1);
        chk1("a_in_ready_gap", in_ready, 1'b0);
        @(negedge clk);
        chk1("a_in_ready_c5", in_ready, 1'b1);
        drain();

        // Spurious done while idle
        step();
        spur_res  = 32'hDEAD_BEEF;
        spur_done = 1'b1;
        step();
        spur_done = 1'b0;
        @(negedge clk);
        chk1("sp_ovalid", out_valid, 1'b0);
        chk1("sp_busy", busy, 1'b0);
        chk1("sp_in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        chk1("sp_start", enc_start, 1'b0);

        // Rolling key, packet restart, key_load ignored while busy, throughput
        load(32'h8000_0001);
        send(32'h0, 1'b0, 1'b1, {32'h8000_0001, 1'b0});
        t1 = t_hs;
        load(32'hFFFF_FFFF);
        send(32'h0, 1'b0, 1'b1, {32'h0000_0003, 1'b0});
        chk32("b_throughput", 32'(t_hs - t1), 32'd50);
        send(32'h0, 1'b1, 1'b1, {32'h0000_0006, 1'b1});
        send(32'h0, 1'b0, 1'b1, {32'h8000_0001, 1'b0});
        drain();

        // Back-pressure: FIFO fills, in_ready drops, then everything drains in order
        load(32'h0F0F_0000);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(xd(i), 1'b0, 1'b1, {xc(i), 1'b0});
        repeat (5) @(negedge clk);
        chk1("c_full_in_ready", in_ready, 1'b0);
        chk1("c_ovalid", out_valid, 1'b1);
        chk32("c_head", out_data, xc(0));
        repeat (3) @(negedge clk);
        chk1("c_full_in_ready2", in_ready, 1'b0);
        chk32("c_head_hold", out_data, xc(0));
        step();
        out_ready = 1'b1;
        send(xd(4), 1'b0, 1'b1, {xc(4), 1'b0});
        send(xd(5), 1'b1, 1'b1, {xc(5), 1'b1});
        drain();

        // Engine timeout: err after TO cycles, no more input, queued result still drains
        load(32'h1111_0000);
        out_ready = 1'b0;
        send(32'h0000_2222, 1'b0, 1'b1, {32'h1111_2222, 1'b0});
        repeat (2) @(negedge clk);
        eng_en = 1'b0;
        send(32'h0000_3333, 1'b0, 1'b0, 33'h0);
        @(negedge clk);
        chk1("d_start", enc_start, 1'b1);
        repeat (TO - 1) @(negedge clk);
        chk1("d_err_early", err, 1'b0);
        @(negedge clk);
        chk1("d_err", err, 1'b1);
        chk1("d_in_ready", in_ready, 1'b0);
        chk1("d_ovalid", out_valid, 1'b1);
        step();
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk1("d_drained", out_valid, 1'b0);
        chk1("d_busy", busy, 1'b1);
        chk1("d_in_ready2", in_ready, 1'b0);
        step();
        in_valid = 1'b1;
        in_data  = 32'h0000_5555;
        n_st     = 0;
        repeat (6) begin
            @(negedge clk);
            if (enc_start) n_st++;
        end
        chk32("d_no_start", n_st, 0);
        in_valid = 1'b0;
        eng_en   = 1'b1;

        // Reset recovery from ERR, then reset with a word in flight and a late done
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk1("e_err_clr", err, 1'b0);
        chk1("e_in_ready", in_ready, 1'b1);
        load(32'h00FF_00FF);
        send(32'hA5A5_A5A5, 1'b1, 1'b0, 33'h0);
        @(negedge clk);
        chk1("e_start", enc_start, 1'b1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk1("e_rst_in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("e_ovalid", out_valid, 1'b0);
        chk1("e_busy", busy, 1'b0);
        chk1("e_enc_start", enc_start, 1'b0);
        chk1("e_err", err, 1'b0);
        chk1("e_out_last", out_last, 1'b0);
        chk32("e_enc_data", enc_data, 32'h0);
        chk32("e_enc_key", enc_key, 32'h0);
        chk32("e_out_data", out_data, 32'h0);
        repeat (2) @(negedge clk);
        chk1("e_no_write", out_valid, 1'b0);
        chk1("e_idle", busy, 1'b0);
        load(32'h0000_FFFF);
        send(32'h1357_2468, 1'b1, 1'b1, {32'h1357_DB97, 1'b1});
        drain();
        repeat (3) @(negedge clk);
        chk1("e_final_empty", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
